// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: ALU op codes, default widths and
// forwarding-source encoding used by the ID/EX stage.
package mips_pkg;

    localparam int DW_DEF = 32;
    localparam int AW_DEF = 5;

    typedef enum logic [3:0] {
        ALU_AND = 4'd0,
        ALU_ADD = 4'd2,
        ALU_SUB = 4'd6,
        ALU_SLT = 4'd7,
        ALU_NOR = 4'd12,
        ALU_SLL = 4'd14
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_MEMWB = 2'd1,
        FWD_EXMEM = 2'd2
    } fwd_sel_e;

endpackage

// File: rtl/forward_unit.sv
// Single-operand forwarding select: EX/MEM beats MEM/WB beats register file.
// Register 0 is hard-wired and never forwarded.
module forward_unit
    import mips_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic [AW-1:0] src_addr,
    input  logic [DW-1:0] rf_data,
    input  logic          exmem_reg_write,
    input  logic [AW-1:0] exmem_dest,
    input  logic [DW-1:0] exmem_result,
    input  logic          memwb_reg_write,
    input  logic [AW-1:0] memwb_dest,
    input  logic [DW-1:0] memwb_data,
    output logic [DW-1:0] data
);

    fwd_sel_e sel;

    always_comb begin
        sel = FWD_RF;
        if (exmem_reg_write && (exmem_dest != '0) && (exmem_dest == src_addr))
            sel = FWD_EXMEM;
        else if (memwb_reg_write && (memwb_dest != '0) && (memwb_dest == src_addr))
            sel = FWD_MEMWB;
    end

    always_comb begin
        data = rf_data;
        case (sel)
            FWD_EXMEM: data = exmem_result;
            FWD_MEMWB: data = memwb_data;
            default:   data = rf_data;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, immediate select and
// load-use stall detection. Optional macro ID_EX_STALL_CNT_EN adds stall_count.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs_addr,
    input  logic [AW-1:0] id_rt_addr,
    input  logic [AW-1:0] id_dest,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic [4:0]    id_shamt,
    input  logic [3:0]    id_alu_control,
    input  logic          id_alu_src,
    input  logic          id_use_rs,
    input  logic          id_use_rt,
    input  logic          id_reg_write,
    input  logic          id_mem_read,
    input  logic          id_mem_write,
    input  logic          id_mem_to_reg,
    input  logic          flush,
    input  logic          exmem_reg_write,
    input  logic [AW-1:0] exmem_dest,
    input  logic [DW-1:0] exmem_result,
    input  logic          memwb_reg_write,
    input  logic [AW-1:0] memwb_dest,
    input  logic [DW-1:0] memwb_data,
    output logic          stall,
    output logic          ex_valid,
    output logic [DW-1:0] alu_rs,
    output logic [DW-1:0] alu_rt,
    output logic [4:0]    alu_shamt,
    output logic [3:0]    alu_control,
    output logic [DW-1:0] ex_store_data,
    output logic [AW-1:0] ex_dest,
    output logic          ex_reg_write,
    output logic          ex_mem_read,
    output logic          ex_mem_write,
    output logic          ex_mem_to_reg
`ifdef ID_EX_STALL_CNT_EN
    ,
    output logic [31:0]   stall_count
`endif
);

    logic [AW-1:0] ex_rs_addr, ex_rt_addr;
    logic [DW-1:0] ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]    ex_shamt;
    logic [3:0]    ex_alu_control;
    logic          ex_alu_src;
    logic [DW-1:0] fwd_rs, fwd_rt;
    logic          rs_hit, rt_hit, bubble;

    // Load-use: the load's data is not available until MEM, so ID must wait one cycle.
    assign rs_hit = id_use_rs && (id_rs_addr == ex_dest);
    assign rt_hit = id_use_rt && (id_rt_addr == ex_dest);
    assign stall  = ex_valid && ex_mem_read && (ex_dest != '0) && id_valid && (rs_hit || rt_hit);
    assign bubble = flush || stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid       <= 1'b0;
            ex_reg_write   <= 1'b0;
            ex_mem_read    <= 1'b0;
            ex_mem_write   <= 1'b0;
            ex_mem_to_reg  <= 1'b0;
            ex_rs_addr     <= '0;
            ex_rt_addr     <= '0;
            ex_dest        <= '0;
            ex_rs_data     <= '0;
            ex_rt_data     <= '0;
            ex_imm         <= '0;
            ex_shamt       <= '0;
            ex_alu_control <= '0;
            ex_alu_src     <= 1'b0;
        end else if (bubble) begin
            // Only the state-changing controls must die; datapath fields are don't-care.
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
        end else begin
            ex_valid       <= id_valid;
            ex_reg_write   <= id_reg_write;
            ex_mem_read    <= id_mem_read;
            ex_mem_write   <= id_mem_write;
            ex_mem_to_reg  <= id_mem_to_reg;
            ex_rs_addr     <= id_rs_addr;
            ex_rt_addr     <= id_rt_addr;
            ex_dest        <= id_dest;
            ex_rs_data     <= id_rs_data;
            ex_rt_data     <= id_rt_data;
            ex_imm         <= id_imm;
            ex_shamt       <= id_shamt;
            ex_alu_control <= id_alu_control;
            ex_alu_src     <= id_alu_src;
        end
    end

    forward_unit #(.DW(DW), .AW(AW)) u_fwd_rs (
        .src_addr        (ex_rs_addr),
        .rf_data         (ex_rs_data),
        .exmem_reg_write (exmem_reg_write),
        .exmem_dest      (exmem_dest),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_dest      (memwb_dest),
        .memwb_data      (memwb_data),
        .data            (fwd_rs)
    );

    forward_unit #(.DW(DW), .AW(AW)) u_fwd_rt (
        .src_addr        (ex_rt_addr),
        .rf_data         (ex_rt_data),
        .exmem_reg_write (exmem_reg_write),
        .exmem_dest      (exmem_dest),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_dest      (memwb_dest),
        .memwb_data      (memwb_data),
        .data            (fwd_rt)
    );

    assign alu_rs        = fwd_rs;
    assign alu_rt        = ex_alu_src ? ex_imm : fwd_rt;
    assign ex_store_data = fwd_rt;
    assign alu_shamt     = ex_shamt;
    assign alu_control   = ex_alu_control;

`ifdef ID_EX_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_count <= '0;
        else if (stall)
            stall_count <= stall_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; stall_count is checked when
// ID_EX_STALL_CNT_EN is defined.
module tb_id_ex_stage;
    import mips_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk, rst_n;
    logic          id_valid;
    logic [AW-1:0] id_rs_addr, id_rt_addr, id_dest;
    logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]    id_shamt;
    logic [3:0]    id_alu_control;
    logic          id_alu_src, id_use_rs, id_use_rt;
    logic          id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic          flush;
    logic          exmem_reg_write, memwb_reg_write;
    logic [AW-1:0] exmem_dest, memwb_dest;
    logic [DW-1:0] exmem_result, memwb_data;
    logic          stall, ex_valid;
    logic [DW-1:0] alu_rs, alu_rt, ex_store_data;
    logic [4:0]    alu_shamt;
    logic [3:0]    alu_control;
    logic [AW-1:0] ex_dest;
    logic          ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
`ifdef ID_EX_STALL_CNT_EN
    logic [31:0]   stall_count;
`endif

    int errors = 0;
    int checks = 0;

    id_ex_stage #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_dest(id_dest),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_shamt(id_shamt), .id_alu_control(id_alu_control), .id_alu_src(id_alu_src),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .flush(flush), .exmem_reg_write(exmem_reg_write), .exmem_dest(exmem_dest),
        .exmem_result(exmem_result), .memwb_reg_write(memwb_reg_write),
        .memwb_dest(memwb_dest), .memwb_data(memwb_data), .stall(stall),
        .ex_valid(ex_valid), .alu_rs(alu_rs), .alu_rt(alu_rt), .alu_shamt(alu_shamt),
        .alu_control(alu_control), .ex_store_data(ex_store_data), .ex_dest(ex_dest),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg)
`ifdef ID_EX_STALL_CNT_EN
        , .stall_count(stall_count)
`endif
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] dst, input logic [31:0] rsd, input logic [31:0] rtd,
                          input logic [3:0] op, input logic urs, input logic urt,
                          input logic rw, input logic mr);
        id_valid = v; id_rs_addr = rs; id_rt_addr = rt; id_dest = dst;
        id_rs_data = rsd; id_rt_data = rtd; id_alu_control = op;
        id_use_rs = urs; id_use_rt = urt; id_reg_write = rw; id_mem_read = mr;
        id_mem_to_reg = mr; id_mem_write = 1'b0; id_alu_src = 1'b0; id_imm = '0; id_shamt = '0;
    endtask

    task automatic clear_fwd();
        exmem_reg_write = 0; exmem_dest = '0; exmem_result = '0;
        memwb_reg_write = 0; memwb_dest = '0; memwb_data = '0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 0; flush = 0; clear_fwd();
        set_id(0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0);
        #3;
        checks++; if (ex_valid !== 1'b0 || stall !== 1'b0 || alu_control !== 4'd0 || alu_rs !== 32'd0 || alu_rt !== 32'd0) begin
            errors++; $display("FAIL reset_state: valid=%b stall=%b op=%h rs=%h rt=%h, want 0", ex_valid, stall, alu_control, alu_rs, alu_rt); end
        @(negedge clk); rst_n = 1;
        set_id(1, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, ALU_ADD, 1, 1, 1, 0);
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_reg_write !== 1'b1 || alu_control !== 4'(ALU_ADD)) begin
            errors++; $display("FAIL capture: valid=%b rw=%b op=%h, want 1 1 2", ex_valid, ex_reg_write, alu_control); end
        #5 rst_n = 0; #1;
        checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || alu_control !== 4'd0) begin
            errors++; $display("FAIL async_reset: valid=%b rw=%b op=%h, want 0 0 0", ex_valid, ex_reg_write, alu_control); end
        @(negedge clk); rst_n = 1;
    endtask

    task automatic test_exmem_fwd();
        clear_fwd();
        set_id(1, 5'd8, 5'd4, 5'd10, 32'h99, 32'h44, ALU_ADD, 1, 1, 1, 0);
        tick();
        checks++; if (alu_rs !== 32'h99) begin
            errors++; $display("FAIL rf_path: alu_rs=%h want 99", alu_rs); end
        exmem_reg_write = 1; exmem_dest = 5'd8; exmem_result = 32'h11; #1;
        checks++; if (alu_rs !== 32'h11 || alu_control !== 4'(ALU_ADD)) begin
            errors++; $display("FAIL exmem_fwd: alu_rs=%h op=%h want 11 2", alu_rs, alu_control); end
        memwb_reg_write = 1; memwb_dest = 5'd8; memwb_data = 32'h22; #1;
        checks++; if (alu_rs !== 32'h11) begin
            errors++; $display("FAIL exmem_priority: alu_rs=%h want 11", alu_rs); end
        exmem_reg_write = 0; #1;
        checks++; if (alu_rs !== 32'h22) begin
            errors++; $display("FAIL memwb_fwd: alu_rs=%h want 22", alu_rs); end
        clear_fwd();
    endtask

    task automatic test_reg0();
        set_id(1, 5'd0, 5'd0, 5'd11, 32'h0, 32'h0, ALU_AND, 1, 1, 1, 0);
        tick();
        exmem_reg_write = 1; exmem_dest = 5'd0; exmem_result = 32'h55;
        memwb_reg_write = 1; memwb_dest = 5'd0; memwb_data = 32'h66; #1;
        checks++; if (alu_rs !== 32'h0 || ex_store_data !== 32'h0) begin
            errors++; $display("FAIL reg0_no_fwd: alu_rs=%h store=%h want 0 0", alu_rs, ex_store_data); end
        clear_fwd();
    endtask

    task automatic test_load_use();
`ifdef ID_EX_STALL_CNT_EN
        logic [31:0] c0;
`endif
        set_id(1, 5'd1, 5'd0, 5'd9, 32'h0, 32'h0, ALU_ADD, 1, 0, 1, 1);
        tick();
`ifdef ID_EX_STALL_CNT_EN
        c0 = stall_count;
`endif
        set_id(1, 5'd9, 5'd9, 5'd10, 32'h777, 32'h888, ALU_ADD, 0, 0, 1, 0); #1;
        checks++; if (stall !== 1'b0) begin
            errors++; $display("FAIL no_use_no_stall: stall=%b want 0", stall); end
        id_use_rs = 1; id_rt_addr = 5'd2; #1;
        checks++; if (stall !== 1'b1) begin
            errors++; $display("FAIL load_use_stall: stall=%b want 1", stall); end
        tick();
        checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0 || stall !== 1'b0) begin
            errors++; $display("FAIL bubble: valid=%b rw=%b mr=%b stall=%b want 0 0 0 0", ex_valid, ex_reg_write, ex_mem_read, stall); end
`ifdef ID_EX_STALL_CNT_EN
        checks++; if (stall_count !== c0 + 32'd1) begin
            errors++; $display("FAIL stall_count_lu: got %0d want %0d", stall_count, c0 + 32'd1); end
`endif
        memwb_reg_write = 1; memwb_dest = 5'd9; memwb_data = 32'hABC;
        tick();
        checks++; if (ex_valid !== 1'b1 || alu_rs !== 32'hABC || ex_dest !== 5'd10) begin
            errors++; $display("FAIL after_stall: valid=%b alu_rs=%h dest=%0d want 1 abc 10", ex_valid, alu_rs, ex_dest); end
        clear_fwd();
    endtask

    task automatic test_imm();
        set_id(1, 5'd0, 5'd3, 5'd12, 32'h0, 32'h77, ALU_SLT, 1, 0, 1, 0);
        id_alu_src = 1; id_imm = 32'hFFFF_FFFC;
        tick();
        exmem_reg_write = 1; exmem_dest = 5'd3; exmem_result = 32'h5; #1;
        checks++; if (alu_rt !== 32'hFFFF_FFFC || ex_store_data !== 32'h5) begin
            errors++; $display("FAIL imm_select: alu_rt=%h store=%h want fffffffc 5", alu_rt, ex_store_data); end
        clear_fwd();
    endtask

    task automatic test_flush_stall();
`ifdef ID_EX_STALL_CNT_EN
        logic [31:0] c0;
`endif
        set_id(1, 5'd1, 5'd0, 5'd9, 32'h0, 32'h0, ALU_ADD, 1, 0, 1, 1);
        tick();
`ifdef ID_EX_STALL_CNT_EN
        c0 = stall_count;
`endif
        set_id(1, 5'd9, 5'd2, 5'd13, 32'h1, 32'h2, ALU_SUB, 1, 1, 1, 0);
        flush = 1; #1;
        checks++; if (stall !== 1'b1) begin
            errors++; $display("FAIL flush_stall_drive: stall=%b want 1", stall); end
        tick();
        checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0) begin
            errors++; $display("FAIL flush_stall_bubble: valid=%b rw=%b mr=%b want 0 0 0", ex_valid, ex_reg_write, ex_mem_read); end
`ifdef ID_EX_STALL_CNT_EN
        checks++; if (stall_count !== c0 + 32'd1) begin
            errors++; $display("FAIL stall_count_fs: got %0d want %0d", stall_count, c0 + 32'd1); end
`endif
        tick();
        checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin
            errors++; $display("FAIL flush_only: valid=%b rw=%b want 0 0", ex_valid, ex_reg_write); end
`ifdef ID_EX_STALL_CNT_EN
        checks++; if (stall_count !== c0 + 32'd1) begin
            errors++; $display("FAIL stall_count_flush_only: got %0d want %0d", stall_count, c0 + 32'd1); end
`endif
        flush = 0;
    endtask

    task automatic test_back_to_back();
        set_id(1, 5'd3, 5'd4, 5'd14, 32'h10, 32'h20, ALU_SUB, 1, 1, 1, 0);
        id_shamt = 5'd7;
        tick();
        set_id(1, 5'd5, 5'd6, 5'd15, 32'h30, 32'h40, ALU_SLL, 0, 1, 1, 0);
        id_shamt = 5'd31; id_mem_write = 1; #1;
        checks++; if (alu_rs !== 32'h10 || alu_rt !== 32'h20 || alu_control !== 4'(ALU_SUB) || alu_shamt !== 5'd7 || ex_dest !== 5'd14) begin
            errors++; $display("FAIL b2b_first: rs=%h rt=%h op=%h sh=%0d dest=%0d want 10 20 6 7 14", alu_rs, alu_rt, alu_control, alu_shamt, ex_dest); end
        tick();
        checks++; if (alu_rs !== 32'h30 || alu_rt !== 32'h40 || alu_control !== 4'(ALU_SLL) || alu_shamt !== 5'd31 || ex_mem_write !== 1'b1) begin
            errors++; $display("FAIL b2b_second: rs=%h rt=%h op=%h sh=%0d mw=%b want 30 40 e 31 1", alu_rs, alu_rt, alu_control, alu_shamt, ex_mem_write); end
        set_id(0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0);
        tick();
        checks++; if (ex_valid !== 1'b0 || ex_mem_write !== 1'b0) begin
            errors++; $display("FAIL idle: valid=%b mw=%b want 0 0", ex_valid, ex_mem_write); end
    endtask

    initial begin
        test_reset();
        test_exmem_fwd();
        test_reg0();
        test_load_use();
        test_imm();
        test_flush_stall();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
